adc_trig_capture: RTL and testbench

ADC_TRIG_CAPTURE -- requirements
Module: adc_trig_capture

---
 rtl/adc_trig_capture_pkg.sv | 27 ++
 rtl/adc_trig_capture_if.sv | 25 ++
 rtl/adc_decim_strobe.sv | 32 +++
 rtl/adc_trig_capture.sv | 193 +++++++++++++++++++
 tb/tb_adc_trig_capture.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_trig_capture_pkg.sv
// Shared definitions for the triggered ADC capture block: FSM encoding and the cfg word layout
// (the SPI config register map uses the same field positions).
package adc_trig_capture_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4
  } cap_state_e;

  localparam int unsigned SampleW     = 8;
  localparam int unsigned CfgLevelLsb = 0;
  localparam int unsigned CfgLevelW   = 8;
  localparam int unsigned CfgSrcBit   = 8;
  localparam int unsigned CfgEdgeBit  = 9;
  localparam int unsigned CfgPostLsb  = 10;
  localparam int unsigned CfgPostW    = 11;
  localparam int unsigned CfgDecLsb   = 24;
  localparam int unsigned CfgDecW     = 8;

  function automatic logic is_busy(input cap_state_e st);
    return st inside {StPre, StArmed, StPost};
  endfunction

endpackage

// File: rtl/adc_trig_capture_if.sv
// Capture buffer write port plus the trigger pointer handed to the SPI buffer reader.
interface adc_trig_capture_if #(
  parameter int unsigned AW = 11
) ();

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic [AW:0]   trig_addr;

  modport master (
    output mem_we,
    output mem_waddr,
    output mem_wdata,
    output trig_addr
  );

  modport slave (
    input mem_we,
    input mem_waddr,
    input mem_wdata,
    input trig_addr
  );

endinterface

// File: rtl/adc_decim_strobe.sv
// Decimation strobe generator: one strobe every (dec+1) clocks, restartable by clr.
module adc_decim_strobe
  import adc_trig_capture_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [CfgDecW-1:0] dec,
  output logic               strobe
);

  logic [CfgDecW-1:0] cnt_q, cnt_d;

  // >= keeps the strobe alive if dec is lowered below the running count
  assign strobe = (cnt_q >= dec);

  always_comb begin
    cnt_d = cnt_q + CfgDecW'(1);
    if (clr || strobe) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered two-channel ADC capture into a circular buffer with pre/post-trigger windows.
// Optional ADC_AUTO_TRIG_EN adds an auto-trigger after AUTO_TO idle ARMED strobes.
module adc_trig_capture
  import adc_trig_capture_pkg::*;
#(
  parameter int unsigned AW      = 11,
  parameter int unsigned AUTO_TO = 1048576
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SampleW-1:0]        adc_a,
  input  logic [SampleW-1:0]        adc_b,
  input  logic [31:0]               cfg,
  input  logic                      arm,
  adc_trig_capture_if.master        mem,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned Depth = 2 ** AW;

  logic [CfgLevelW-1:0] level;
  logic                 src_b;
  logic                 rising;
  logic [CfgPostW-1:0]  post;
  logic [CfgDecW-1:0]   dec;
  logic                 unused_cfg;

  assign level      = cfg[CfgLevelLsb +: CfgLevelW];
  assign src_b      = cfg[CfgSrcBit];
  assign rising     = cfg[CfgEdgeBit];
  assign post       = cfg[CfgPostLsb +: CfgPostW];
  assign dec        = cfg[CfgDecLsb +: CfgDecW];
  assign unused_cfg = ^cfg[CfgDecLsb-1:CfgPostLsb+CfgPostW];

  cap_state_e           state_q, state_d;
  logic [AW:0]          pre_cnt_q, pre_cnt_d, pre_inc, pre_target;
  logic [CfgPostW:0]    post_cnt_q, post_cnt_d, post_inc, post_ext;
  logic [AW-1:0]        wptr_q;
  logic [SampleW-1:0]   prev_q, sel;
  logic                 prev_valid_q;
  logic                 we_q;
  logic [AW-1:0]        waddr_q;
  logic [15:0]          wdata_q;
  logic [AW:0]          trig_q, trig_d;
  logic                 strobe, write_en, edge_hit, auto_fire;

  adc_decim_strobe u_decim (
    .clk    (clk),
    .rst    (rst),
    .clr    (arm),
    .dec    (dec),
    .strobe (strobe)
  );

  // Pre-trigger fill: whatever the post window leaves of the buffer, never negative.
  always_comb begin
    if (32'(post) >= Depth - 1) begin
      pre_target = '0;
    end else begin
      pre_target = (AW+1)'(Depth - 1 - 32'(post));
    end
  end

  assign pre_inc  = pre_cnt_q + (AW+1)'(1);
  assign post_inc = post_cnt_q + (CfgPostW+1)'(1);
  assign post_ext = {1'b0, post};
  assign sel      = src_b ? adc_b : adc_a;

  // An arm cycle never writes; it only restarts the capture.
  assign write_en = strobe && is_busy(state_q) && !arm;

  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid_q) begin
      if (rising) begin
        edge_hit = (prev_q < level) && (sel >= level);
      end else begin
        edge_hit = (prev_q >= level) && (sel < level);
      end
    end
  end

`ifdef ADC_AUTO_TRIG_EN
  localparam int unsigned ToW = $clog2(AUTO_TO + 1);

  logic [ToW-1:0] to_cnt_q;

  assign auto_fire = (to_cnt_q == ToW'(AUTO_TO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (arm || (state_q != StArmed)) begin
      to_cnt_q <= '0;
    end else if (strobe && !auto_fire) begin
      to_cnt_q <= to_cnt_q + ToW'(1);
    end
  end
`else
  logic [31:0] unused_auto_to;

  assign unused_auto_to = AUTO_TO;
  assign auto_fire      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    trig_d     = trig_q;
    if (arm) begin
      state_d    = StPre;
      pre_cnt_d  = '0;
      post_cnt_d = '0;
      trig_d[AW] = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
        end
        StPre: begin
          if (pre_target == '0) begin
            state_d = StArmed;
          end else if (strobe) begin
            pre_cnt_d = pre_inc;
            if (pre_inc >= pre_target) begin
              state_d = StArmed;
            end
          end
        end
        StArmed: begin
          if (strobe && (edge_hit || auto_fire)) begin
            trig_d     = {1'b1, wptr_q};
            post_cnt_d = '0;
            // With no post window the trigger sample is the last write.
            state_d    = (post == '0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (post == '0) begin
            state_d = StDone;
          end else if (strobe) begin
            post_cnt_d = post_inc;
            if (post_inc >= post_ext) begin
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_q       <= '0;
      wptr_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      trig_q     <= trig_d;
      we_q       <= write_en;
      if (write_en) begin
        waddr_q <= wptr_q;
        wdata_q <= {adc_b, adc_a};
        wptr_q  <= wptr_q + AW'(1);
      end
      if (arm) begin
        prev_valid_q <= 1'b0;
      end else if (strobe) begin
        prev_q       <= sel;
        prev_valid_q <= 1'b1;
      end
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_waddr = waddr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.trig_addr = trig_q;
  assign busy          = is_busy(state_q);
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_adc_trig_capture.sv
// Directed bench for adc_trig_capture: capture windows, edges, decimation, re-arm/reset, timeout.
module tb_adc_trig_capture;

  localparam int unsigned AW = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adc_a = '0;
  logic [7:0]  adc_b = '0;
  logic [31:0] cfg = '0;
  logic        arm = 1'b0;
  logic        busy, done;

  adc_trig_capture_if #(.AW(AW)) mem_bus ();

  adc_trig_capture #(
    .AW      (AW),
    .AUTO_TO (64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .adc_a (adc_a),
    .adc_b (adc_b),
    .cfg   (cfg),
    .arm   (arm),
    .mem   (mem_bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   mem_model [2**AW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and record any write seen on the buffer port.
  task automatic tick();
    @(negedge clk);
    if (mem_bus.mem_we === 1'b1) begin
      wr_cnt++;
      last_addr = mem_bus.mem_waddr;
      mem_model[mem_bus.mem_waddr] = mem_bus.mem_wdata;
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [31:0] mk_cfg(input logic [7:0] dec, input logic [10:0] post,
                                         input logic rising, input logic src_b,
                                         input logic [7:0] level);
    return {dec, 3'b000, post, rising, src_b, level};
  endfunction

  initial begin
    int first_idx, prev_idx, bad_gap, bad_addr, nwr;

    tick();
    tick();
    check_eq("rst_we", 32'(mem_bus.mem_we), 0);
    check_eq("rst_waddr", 32'(mem_bus.mem_waddr), 0);
    check_eq("rst_wdata", 32'(mem_bus.mem_wdata), 0);
    check_eq("rst_trig", 32'(mem_bus.trig_addr), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    rst = 1'b0;
    tick();
    tick();
    check_eq("idle_no_write", 32'(wr_cnt), 0);

    // Rising ramp on A, post=16: 2031 pre writes, trigger at write 2176 (addr 128).
    cfg    = mk_cfg(8'd0, 11'd16, 1'b1, 1'b0, 8'h80);
    adc_b  = 8'h00;
    wr_cnt = 0;
    pulse_arm();
    for (int i = 0; i < 5000; i++) begin
      adc_a = 8'(i);
      tick();
      if (done) break;
    end
    check_eq("ramp_writes", 32'(wr_cnt), 2193);
    check_eq("ramp_trig_addr", 32'(mem_bus.trig_addr), 32'h880);
    check_eq("ramp_trig_data", 32'(mem_model[128]), 32'h0080);
    check_eq("ramp_last_addr", 32'(last_addr), 144);
    check_eq("ramp_done", 32'(done), 1);
    check_eq("ramp_not_busy", 32'(busy), 0);
    repeat (20) tick();
    check_eq("done_no_write", 32'(wr_cnt), 2193);

    // Same ramp, post=0: pointer starts at 145, trigger is the final write.
    cfg    = mk_cfg(8'd0, 11'd0, 1'b1, 1'b0, 8'h80);
    wr_cnt = 0;
    pulse_arm();
    for (int i = 0; i < 5000; i++) begin
      adc_a = 8'(i);
      tick();
      if (done) break;
    end
    check_eq("post0_writes", 32'(wr_cnt), 2177);
    check_eq("post0_trig_addr", 32'(mem_bus.trig_addr), 32'h911);
    check_eq("post0_last_addr", 32'(last_addr), 273);
    check_eq("post0_trig_data", 32'(mem_model[273]), 32'h0080);
    check_eq("post0_done", 32'(done), 1);

    // Falling edge on B at level 0x40, one-clock PRE; pointer starts at 274.
    cfg    = mk_cfg(8'd0, 11'h7ff, 1'b0, 1'b1, 8'h40);
    adc_a  = 8'h00;
    wr_cnt = 0;
    pulse_arm();
    adc_b = 8'h40; tick();
    adc_b = 8'h40; tick();
    adc_b = 8'h40; tick();
    adc_b = 8'h50; tick();
    check_eq("flat_no_trig", 32'(mem_bus.trig_addr[AW]), 0);
    check_eq("flat_busy", 32'(busy), 1);
    adc_b = 8'h30; tick();
    check_eq("fall_trig_addr", 32'(mem_bus.trig_addr), 32'h916);
    check_eq("fall_trig_data", 32'(mem_model[278]), 32'h3000);

    // Re-arm while in POST, then reset while in POST again.
    pulse_arm();
    check_eq("rearm_valid_clr", 32'(mem_bus.trig_addr[AW]), 0);
    check_eq("rearm_busy", 32'(busy), 1);
    check_eq("rearm_done", 32'(done), 0);
    adc_b = 8'h50; tick();
    adc_b = 8'h30; tick();
    check_eq("retrig_valid", 32'(mem_bus.trig_addr[AW]), 1);
    rst = 1'b1;
    tick();
    check_eq("abort_we", 32'(mem_bus.mem_we), 0);
    check_eq("abort_waddr", 32'(mem_bus.mem_waddr), 0);
    check_eq("abort_wdata", 32'(mem_bus.mem_wdata), 0);
    check_eq("abort_trig", 32'(mem_bus.trig_addr), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    rst    = 1'b0;
    wr_cnt = 0;
    repeat (5) tick();
    check_eq("abort_no_write", 32'(wr_cnt), 0);

    // Decimation by 4: first write visible 4 clocks after arm, then every 4th clock.
    cfg       = mk_cfg(8'd3, 11'h7ff, 1'b1, 1'b0, 8'hff);
    adc_a     = 8'h00;
    adc_b     = 8'h00;
    first_idx = -1;
    prev_idx  = -1;
    bad_gap   = 0;
    bad_addr  = 0;
    nwr       = 0;
    pulse_arm();
    for (int j = 1; j <= 41; j++) begin
      tick();
      if (mem_bus.mem_we === 1'b1) begin
        if (mem_bus.mem_waddr != AW'(nwr)) bad_addr++;
        nwr++;
        if (first_idx < 0) first_idx = j;
        else if (j - prev_idx != 4) bad_gap++;
        prev_idx = j;
      end
    end
    check_eq("dec_first_idx", 32'(first_idx), 4);
    check_eq("dec_count", 32'(nwr), 10);
    check_eq("dec_gap", 32'(bad_gap), 0);
    check_eq("dec_addr_seq", 32'(bad_addr), 0);
    check_eq("dec_last_addr", 32'(last_addr), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Constant input: no natural trigger; optional timeout fires on the 65th ARMED strobe.
    cfg   = mk_cfg(8'd0, 11'h7ff, 1'b1, 1'b0, 8'h80);
    adc_a = 8'h10;
    pulse_arm();
    repeat (65) tick();
    check_eq("to_before_valid", 32'(mem_bus.trig_addr[AW]), 0);
    check_eq("to_before_busy", 32'(busy), 1);
`ifdef ADC_AUTO_TRIG_EN
    tick();
    check_eq("to_forced_trig", 32'(mem_bus.trig_addr), 32'h841);
`else
    repeat (936) tick();
    check_eq("no_to_valid", 32'(mem_bus.trig_addr[AW]), 0);
    check_eq("no_to_busy", 32'(busy), 1);
    check_eq("no_to_done", 32'(done), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
